// File: rtl/lsu_mem_initiator.sv
// Load/store unit memory initiator: turns one CPU load/store request into one
// or two word-wide memory accesses, then returns extended load data.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | first word access (word containing the start address)
// ACC1  | second word access for accesses crossing a word boundary
// RESP  | one-cycle completion pulse
module lsu_mem_initiator (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [29:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [1:0]  off;
  logic [3:0]  mask4;
  logic [7:0]  mask8;
  logic [5:0]  hi_shift;

  function automatic logic is_legal(input logic [2:0] t);
    return (t <= 3'd4);
  endfunction

  function automatic logic is_split(input logic [2:0] t, input logic [1:0] o);
    case (t)
      3'd0:    return (o != 2'd0);
      3'd1,
      3'd2:    return (o == 2'd3);
      default: return 1'b0;
    endcase
  endfunction

  // Extract the addressed bytes from the {hi,lo} pair and extend to 32 bits.
  // Only hi[23:0] can ever reach the result, so only those bits are passed.
  function automatic logic [31:0] load_result(input logic [2:0] t, input logic [23:0] hi,
                                              input logic [31:0] lo, input logic [1:0] o);
    logic [31:0] al;
    case (o)
      2'd0:    al = lo;
      2'd1:    al = {hi[7:0],  lo[31:8]};
      2'd2:    al = {hi[15:0], lo[31:16]};
      default: al = {hi[23:0], lo[31:24]};
    endcase
    case (t)
      3'd1:    return {{16{al[15]}}, al[15:0]};
      3'd2:    return {16'h0, al[15:0]};
      3'd3:    return {{24{al[7]}}, al[7:0]};
      3'd4:    return {24'h0, al[7:0]};
      default: return al;
    endcase
  endfunction

  // Lane mask of the captured access, positioned across two adjacent words.
  always_comb begin
    off = addr_q[1:0];
    case (type_q)
      3'd0:         mask4 = 4'b1111;
      3'd1, 3'd2:   mask4 = 4'b0011;
      default:      mask4 = 4'b0001;
    endcase
    mask8    = {4'b0000, mask4} << off;
    hi_shift = 6'd32 - {1'b0, off, 3'b000};
  end

  // Next-state, capture and output logic.
  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_addr  = 30'h0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          store_d = req_store;
          type_d  = req_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          lo_d    = 32'h0;
          if (is_legal(req_type)) begin
            state_d = ACC0;
          end else begin
            state_d = RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end
        end
      end
      ACC0: begin
        mem_addr  = addr_q[31:2];
        mem_be    = mask8[3:0];
        mem_we    = store_q;
        mem_wdata = wdata_q << {off, 3'b000};
        lo_d      = mem_rdata;
        err_d     = 1'b0;
        if (is_split(type_q, off)) begin
          state_d = ACC1;
        end else begin
          state_d = RESP;
          rdata_d = store_q ? 32'h0 : load_result(type_q, 24'h0, mem_rdata, off);
        end
      end
      ACC1: begin
        mem_addr  = addr_q[31:2] + 30'd1;
        mem_be    = mask8[7:4];
        mem_we    = store_q;
        mem_wdata = wdata_q >> hi_shift;
        state_d   = RESP;
        rdata_d   = store_q ? 32'h0 : load_result(type_q, mem_rdata[23:0], lo_q, off);
      end
      default: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
    endcase

    // Reset takes effect on the edge, but strobes must already be quiet in
    // the cycle it is asserted so an in-flight access commits nothing more.
    if (!rstn) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_addr  = 30'h0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_wdata = 32'h0;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // State and capture registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      type_q  <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
